// File: rtl/ber_meas_controller.sv
// BER measurement sequencer for the 16-QAM loop.
// Searches the tx->rx symbol delay, then counts bit and symbol errors over a
// 2^LOG2_MEAS-symbol window and latches the results.
// Optional macro BER_AUTO_RESTART_EN: after a successful lock, windows repeat
// back to back with a 1-clk done pulse per window; start in MEASURE re-aligns.
module ber_meas_controller #(
  parameter int unsigned MAX_DELAY  = 31,
  parameter int unsigned DLY_W      = 5,
  parameter int unsigned ALIGN_SYMS = 64,
  parameter int unsigned LOG2_MEAS  = 20,
  parameter int unsigned CNT_W      = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_clk_ena,
  input  logic             start,
  input  logic [1:0]       ref_i,
  input  logic [1:0]       ref_q,
  input  logic [1:0]       rx_i,
  input  logic [1:0]       rx_q,
  output logic             busy,
  output logic             locked,
  output logic             lock_fail,
  output logic             done,
  output logic [DLY_W-1:0] delay_out,
  output logic [CNT_W-1:0] bit_errs,
  output logic [CNT_W-1:0] sym_errs,
  output logic [1:0]       state_out
);

  localparam int unsigned AcntW = $clog2(ALIGN_SYMS + 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAlign   = 2'd1,
    StMeasure = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e           state_q;
  logic             busy_q, locked_q, lock_fail_q, done_q, miss_q;
  logic [DLY_W-1:0] delay_q, trial_q;
  logic [AcntW-1:0] align_cnt_q;
  logic [LOG2_MEAS-1:0] win_q;
  logic [CNT_W-1:0] bit_acc_q, sym_acc_q, bit_errs_q, sym_errs_q;

  // dline_q[k] holds the reference symbol from k+1 enables ago; the current
  // input symbol serves as candidate 0.
  logic [3:0] dline_q [MAX_DELAY];
  logic [3:0] taps    [MAX_DELAY+1];

  logic [DLY_W-1:0] sel;
  logic [3:0]       cand, err;
  logic [2:0]       popcnt;
  logic             sym_err, miss_nx, go_align;
  logic [AcntW-1:0] align_inc;
  logic [CNT_W:0]   bit_sum, sym_sum;
  logic [CNT_W-1:0] bit_nx, sym_nx;

  // Delay line of reference symbols, advanced on every symbol enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(MAX_DELAY); k++) dline_q[k] <= '0;
    end else if (sym_clk_ena) begin
      dline_q[0] <= {ref_i, ref_q};
      for (int k = 1; k < int'(MAX_DELAY); k++) dline_q[k] <= dline_q[k-1];
    end
  end

  // Candidate selection, error vector and saturating accumulator next values.
  always_comb begin
    taps[0] = {ref_i, ref_q};
    for (int k = 0; k < int'(MAX_DELAY); k++) taps[k+1] = dline_q[k];
    sel  = (state_q == StMeasure) ? delay_q : trial_q;
    cand = '0;
    for (int k = 0; k <= int'(MAX_DELAY); k++) begin
      if (DLY_W'(k) == sel) cand = taps[k];
    end
    err       = {rx_i, rx_q} ^ cand;
    popcnt    = {2'b00, err[0]} + {2'b00, err[1]} + {2'b00, err[2]} + {2'b00, err[3]};
    sym_err   = |err;
    miss_nx   = miss_q | sym_err;
    align_inc = align_cnt_q + AcntW'(1);
    bit_sum   = {1'b0, bit_acc_q} + (CNT_W+1)'(popcnt);
    sym_sum   = {1'b0, sym_acc_q} + (CNT_W+1)'(sym_err);
    // Carry out of the top bit means the count would wrap: clamp instead.
    bit_nx    = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    sym_nx    = sym_sum[CNT_W] ? '1 : sym_sum[CNT_W-1:0];
  end

`ifdef BER_AUTO_RESTART_EN
  assign go_align = start && (state_q != StAlign);
`else
  assign go_align = start && ((state_q == StIdle) || (state_q == StDone));
`endif

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      lock_fail_q <= 1'b0;
      done_q      <= 1'b0;
      miss_q      <= 1'b0;
      delay_q     <= '0;
      trial_q     <= '0;
      align_cnt_q <= '0;
      win_q       <= '0;
      bit_acc_q   <= '0;
      sym_acc_q   <= '0;
      bit_errs_q  <= '0;
      sym_errs_q  <= '0;
    end else if (go_align) begin
      state_q     <= StAlign;
      busy_q      <= 1'b1;
      trial_q     <= '0;
      align_cnt_q <= '0;
      miss_q      <= 1'b0;
      locked_q    <= 1'b0;
      lock_fail_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAlign: begin
          if (sym_clk_ena) begin
            if (align_inc == AcntW'(ALIGN_SYMS)) begin
              if (!miss_nx) begin
                locked_q  <= 1'b1;
                delay_q   <= trial_q;
                state_q   <= StMeasure;
                win_q     <= '0;
                bit_acc_q <= '0;
                sym_acc_q <= '0;
              end else if (trial_q == DLY_W'(MAX_DELAY)) begin
                lock_fail_q <= 1'b1;
                delay_q     <= '0;
                done_q      <= 1'b1;
                busy_q      <= 1'b0;
                state_q     <= StDone;
              end else begin
                trial_q     <= trial_q + DLY_W'(1);
                align_cnt_q <= '0;
                miss_q      <= 1'b0;
              end
            end else begin
              align_cnt_q <= align_inc;
              miss_q      <= miss_nx;
            end
          end
        end
        StMeasure: begin
          if (sym_clk_ena) begin
            bit_acc_q <= bit_nx;
            sym_acc_q <= sym_nx;
            if (&win_q) begin
              // Final symbol of the window is folded into the latched result.
              bit_errs_q <= bit_nx;
              sym_errs_q <= sym_nx;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= StDone;
            end else begin
              win_q <= win_q + LOG2_MEAS'(1);
            end
          end
        end
        StDone: begin
`ifdef BER_AUTO_RESTART_EN
          if (locked_q) begin
            state_q   <= StMeasure;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            win_q     <= '0;
            bit_acc_q <= '0;
            sym_acc_q <= '0;
          end
`endif
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign locked    = locked_q;
  assign lock_fail = lock_fail_q;
  assign done      = done_q;
  assign delay_out = delay_q;
  assign bit_errs  = bit_errs_q;
  assign sym_errs  = sym_errs_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_ber_meas_controller.sv
// Self-checking bench for ber_meas_controller with a trace-based reference
// model: every enable's ref/rx symbols are logged and expected lock delay and
// error counts are computed from the log.
module tb_ber_meas_controller;

  localparam int MaxDelay  = 31;
  localparam int AlignSyms = 64;
  localparam int Log2Meas  = 10;
  localparam int Win       = 1 << Log2Meas;

  logic clk = 1'b0;
  logic reset = 1'b0, sym_clk_ena = 1'b0, start = 1'b0;
  logic [1:0] ref_i = '0, ref_q = '0, rx_i = '0, rx_q = '0;

  logic        busy, locked, lock_fail, done;
  logic [4:0]  delay_out;
  logic [23:0] bit_errs, sym_errs;
  logic [1:0]  state_out;

  logic        s_busy, s_locked, s_lock_fail, s_done;
  logic [4:0]  s_delay_out;
  logic [3:0]  s_bit_errs, s_sym_errs;
  logic [1:0]  s_state_out;

  ber_meas_controller #(
    .MAX_DELAY(MaxDelay), .DLY_W(5), .ALIGN_SYMS(AlignSyms), .LOG2_MEAS(Log2Meas), .CNT_W(24)
  ) dut (
    .clk(clk), .reset(reset), .sym_clk_ena(sym_clk_ena), .start(start),
    .ref_i(ref_i), .ref_q(ref_q), .rx_i(rx_i), .rx_q(rx_q),
    .busy(busy), .locked(locked), .lock_fail(lock_fail), .done(done),
    .delay_out(delay_out), .bit_errs(bit_errs), .sym_errs(sym_errs), .state_out(state_out)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation.
  ber_meas_controller #(
    .MAX_DELAY(MaxDelay), .DLY_W(5), .ALIGN_SYMS(AlignSyms), .LOG2_MEAS(Log2Meas), .CNT_W(4)
  ) dut_s (
    .clk(clk), .reset(reset), .sym_clk_ena(sym_clk_ena), .start(start),
    .ref_i(ref_i), .ref_q(ref_q), .rx_i(rx_i), .rx_q(rx_q),
    .busy(s_busy), .locked(s_locked), .lock_fail(s_lock_fail), .done(s_done),
    .delay_out(s_delay_out), .bit_errs(s_bit_errs), .sym_errs(s_sym_errs),
    .state_out(s_state_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] ref_hist[$];
  logic [3:0] rx_hist[$];

  // done monitor: enable index at each rising edge, and total high cycles.
  int   done_rise[$];
  int   done_high = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done && !done_prev) done_rise.push_back(ref_hist.size());
    if (done) done_high++;
    done_prev = done;
  end

  function automatic logic [3:0] ref_at(int n);
    if (n < 0) return 4'h0;
    return ref_hist[n];
  endfunction

  // First candidate delay whose 64-symbol trial block matches fully; -1 if none.
  function automatic int model_lock(int b);
    for (int t = 0; t <= MaxDelay; t++) begin
      bit ok = 1'b1;
      if (b + (t + 1) * AlignSyms > rx_hist.size()) return -2;
      for (int j = 0; j < AlignSyms; j++) begin
        int n = b + t * AlignSyms + j;
        if (rx_hist[n] != ref_at(n - t)) ok = 1'b0;
      end
      if (ok) return t;
    end
    return -1;
  endfunction

  // Errors over the window following a lock at delay d, clamped to cw bits.
  function automatic longint model_errs(int b, int d, int cw, bit count_bits);
    longint acc = 0;
    longint lim = (longint'(1) << cw) - 1;
    int st = b + (d + 1) * AlignSyms;
    for (int n = st; n < st + Win; n++) begin
      logic [3:0] e = rx_hist[n] ^ ref_at(n - d);
      acc += count_bits ? longint'($countones(e)) : longint'(e != 4'h0);
    end
    return (acc > lim) ? lim : acc;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sym_clk_ena = 1'b0; start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ref_hist.delete();
    rx_hist.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // One symbol: random ref, rx = ref from dly enables ago xor flip (or zero).
  task automatic do_enable(input int dly, input logic [3:0] flip, input bit zero_rx);
    logic [3:0] r, x;
    int n;
    r = 4'($urandom_range(0, 15));
    ref_hist.push_back(r);
    n = ref_hist.size() - 1;
    x = zero_rx ? 4'h0 : (ref_at(n - dly) ^ flip);
    rx_hist.push_back(x);
    @(negedge clk);
    sym_clk_ena = 1'b1; {ref_i, ref_q} = r; {rx_i, rx_q} = x;
    @(negedge clk);
    sym_clk_ena = 1'b0;
  endtask

  task automatic go_to_measure();
    do_reset();
    pulse_start();
    for (int i = 0; i < 6 * AlignSyms; i++) do_enable(5, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state_out !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state_out);
    end
    checks++;
    if ({busy, locked, lock_fail, done, delay_out} !== 9'd0) begin
      errors++; $display("FAIL reset_flags: got %0h expected 0", {busy, locked, lock_fail, done, delay_out});
    end
    checks++;
    if ({bit_errs, sym_errs} !== 48'd0) begin
      errors++; $display("FAIL reset_counts: got %0h expected 0", {bit_errs, sym_errs});
    end
  endtask

  task automatic test_clean_link();
    int d;
    logic [23:0] eb, es;
    do_reset();
    pulse_start();
    checks++;
    if ({busy, state_out} !== 3'b101) begin
      errors++; $display("FAIL start_align: got %0b expected 101", {busy, state_out});
    end
    for (int i = 0; i < 6 * AlignSyms - 1; i++) do_enable(5, 4'h0, 1'b0);
    checks++;
    if ({locked, state_out} !== 3'b001) begin
      errors++; $display("FAIL pre_lock: got %0b expected 001", {locked, state_out});
    end
    do_enable(5, 4'h0, 1'b0);
    d = model_lock(0);
    checks++;
    if ({locked, delay_out, state_out} !== {d >= 0, (d >= 0) ? 5'(d) : 5'd0, 2'd2}) begin
      errors++; $display("FAIL lock: got locked=%0d delay=%0d state=%0d expected delay %0d",
                         locked, delay_out, state_out, d);
    end
    for (int i = 0; i < Win - 1; i++) do_enable(5, 4'h0, 1'b0);
    checks++;
    if ({done, state_out} !== 3'b010) begin
      errors++; $display("FAIL pre_done: got %0b expected 010", {done, state_out});
    end
    do_enable(5, 4'h0, 1'b0);
    eb = 24'(model_errs(0, d, 24, 1'b1));
    es = 24'(model_errs(0, d, 24, 1'b0));
    checks++;
    if ({done, busy, state_out} !== 4'b1011) begin
      errors++; $display("FAIL window_end: got %0b expected 1011", {done, busy, state_out});
    end
    checks++;
    if ({bit_errs, sym_errs} !== {eb, es}) begin
      errors++; $display("FAIL clean_counts: got %0d/%0d expected %0d/%0d", bit_errs, sym_errs, eb, es);
    end
  endtask

  task automatic test_error_count();
    int base;
    logic [23:0] eb, es;
    logic [3:0] f;
    go_to_measure();
    base = int'($urandom_range(0, 200));
    for (int i = 0; i < Win; i++) begin
      f = 4'h0;
      for (int k = 0; k < 5; k++) begin
        if (i == base + k * 150) f = (k < 3) ? 4'b0100 : 4'b1100;
      end
      do_enable(5, f, 1'b0);
    end
    eb = 24'(model_errs(0, model_lock(0), 24, 1'b1));
    es = 24'(model_errs(0, model_lock(0), 24, 1'b0));
    checks++;
    if ({done, bit_errs, sym_errs} !== {1'b1, eb, es}) begin
      errors++; $display("FAIL err_counts: got done=%0d %0d/%0d expected %0d/%0d",
                         done, bit_errs, sym_errs, eb, es);
    end
  endtask

  task automatic test_lock_fail();
    do_reset();
    pulse_start();
    for (int i = 0; i < (MaxDelay + 1) * AlignSyms - 1; i++) do_enable(0, 4'h0, 1'b1);
    checks++;
    if ({lock_fail, state_out} !== 3'b001) begin
      errors++; $display("FAIL pre_fail: got %0b expected 001", {lock_fail, state_out});
    end
    do_enable(0, 4'h0, 1'b1);
    checks++;
    if ({lock_fail, done, locked, busy, state_out} !== {model_lock(0) == -1, 5'b10011}) begin
      errors++; $display("FAIL lock_fail: got %0b expected %0b",
                         {lock_fail, done, locked, busy, state_out}, {model_lock(0) == -1, 5'b10011});
    end
    checks++;
    if ({delay_out, bit_errs} !== 29'd0) begin
      errors++; $display("FAIL fail_outputs: got delay=%0d bits=%0d expected 0/0", delay_out, bit_errs);
    end
  endtask

  task automatic test_saturation();
    int d;
    logic [3:0]  sb, ss;
    logic [23:0] eb;
    go_to_measure();
    for (int i = 0; i < Win; i++) do_enable(5, 4'hF, 1'b0);
    d  = model_lock(0);
    sb = 4'(model_errs(0, d, 4, 1'b1));
    ss = 4'(model_errs(0, d, 4, 1'b0));
    eb = 24'(model_errs(0, d, 24, 1'b1));
    checks++;
    if ({s_bit_errs, s_sym_errs} !== {sb, ss}) begin
      errors++; $display("FAIL sat_counts: got %0d/%0d expected %0d/%0d", s_bit_errs, s_sym_errs, sb, ss);
    end
    checks++;
    if (bit_errs !== eb) begin
      errors++; $display("FAIL wide_bits: got %0d expected %0d", bit_errs, eb);
    end
  endtask

  task automatic test_reset_mid();
    go_to_measure();
    for (int i = 0; i < 100; i++) do_enable(5, 4'h0, 1'b0);
    pulse_start();
    checks++;
`ifdef BER_AUTO_RESTART_EN
    if (state_out !== 2'd1) begin
      errors++; $display("FAIL start_in_measure: got %0d expected 1", state_out);
    end
`else
    if (state_out !== 2'd2) begin
      errors++; $display("FAIL start_in_measure: got %0d expected 2", state_out);
    end
`endif
    do_reset();
    checks++;
    if ({busy, locked, lock_fail, done, delay_out, bit_errs, sym_errs, state_out} !== 59'd0) begin
      errors++; $display("FAIL reset_mid: got state=%0d locked=%0d delay=%0d expected all 0",
                         state_out, locked, delay_out);
    end
  endtask

`ifdef BER_AUTO_RESTART_EN
  task automatic test_auto_restart();
    int r0, h0;
    go_to_measure();
    r0 = done_rise.size();
    h0 = done_high;
    for (int i = 0; i < 3 * Win; i++) do_enable(5, 4'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (done_rise.size() - r0 !== 3) begin
      errors++; $display("FAIL auto_pulses: got %0d expected 3", done_rise.size() - r0);
    end
    checks++;
    if (done_high - h0 !== 3) begin
      errors++; $display("FAIL auto_width: got %0d expected 3", done_high - h0);
    end
    for (int k = r0 + 1; k < done_rise.size(); k++) begin
      checks++;
      if (done_rise[k] - done_rise[k-1] !== Win) begin
        errors++; $display("FAIL auto_spacing: got %0d expected %0d", done_rise[k] - done_rise[k-1], Win);
      end
    end
    checks++;
    if ({locked, state_out} !== 3'b110) begin
      errors++; $display("FAIL auto_locked: got %0b expected 110", {locked, state_out});
    end
  endtask
`else
  task automatic test_back_to_back();
    logic [23:0] eb, es;
    go_to_measure();
    for (int i = 0; i < Win; i++) do_enable(5, (i < 3) ? 4'b0001 : 4'h0, 1'b0);
    eb = 24'(model_errs(0, model_lock(0), 24, 1'b1));
    es = 24'(model_errs(0, model_lock(0), 24, 1'b0));
    for (int i = 0; i < 20; i++) do_enable(5, 4'b0011, 1'b0);
    checks++;
    if ({done, state_out, bit_errs, sym_errs} !== {3'b111, eb, es}) begin
      errors++; $display("FAIL done_hold: got done=%0d state=%0d %0d/%0d expected %0d/%0d",
                         done, state_out, bit_errs, sym_errs, eb, es);
    end
    pulse_start();
    checks++;
    if ({done, locked, lock_fail, busy, state_out} !== 6'b000101) begin
      errors++; $display("FAIL restart: got %0b expected 000101", {done, locked, lock_fail, busy, state_out});
    end
    checks++;
    if ({bit_errs, sym_errs} !== {eb, es}) begin
      errors++; $display("FAIL results_hold: got %0d/%0d expected %0d/%0d", bit_errs, sym_errs, eb, es);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_link();
    test_error_count();
    test_lock_fail();
    test_saturation();
    test_reset_mid();
`ifdef BER_AUTO_RESTART_EN
    test_auto_restart();
`else
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
